// File: rtl/pulse_train_ctrl_if.sv
// Host-facing bundle for pulse_train_ctrl: config handshake, start/stop controls and burst status.
// The master drives config and controls; the slave (the sequencer) returns cfg_ready, signal and status.
interface pulse_train_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half_period;
  logic [NP_W-1:0]  cfg_num_pulses;
  logic             start;
  logic             stop;
  logic             signal;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NP_W-1:0]  pulse_count;

  modport master (
    output cfg_valid, cfg_half_period, cfg_num_pulses, start, stop,
    input  cfg_ready, signal, busy, done, aborted, pulse_count
  );

  modport slave (
    input  cfg_valid, cfg_half_period, cfg_num_pulses, start, stop,
    output cfg_ready, signal, busy, done, aborted, pulse_count
  );
endinterface

// File: rtl/pulse_train_ctrl.sv
// Pulse-train sequencer: start sampled at edge t0 gives signal high from t0+1, H high / H low per pulse, done at t0+1+2NH.
// Config is accepted only in IDLE (cfg_ready low otherwise, cfg_valid ignored); start/stop are level-sampled, never stalled.
module pulse_train_ctrl #(
  parameter int CNT_W    = 32,
  parameter int NP_W     = 16,
  parameter int DEF_HALF = 8
) (
  input logic               clk,
  input logic               rst,
  pulse_train_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] cnt;
  logic [NP_W-1:0]  np_reg;
  logic             signal_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;
  logic [NP_W-1:0]  pc_r;

  logic             cfg_xfer;
  logic [CNT_W-1:0] cfg_half_eff;
  logic [CNT_W-1:0] start_half;
  logic [NP_W-1:0]  pc_inc;

  assign bus.cfg_ready   = (state == IDLE) && !rst;
  assign bus.signal      = signal_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.aborted     = aborted_r;
  assign bus.pulse_count = pc_r;

  assign cfg_xfer     = bus.cfg_valid && bus.cfg_ready;
  assign cfg_half_eff = (bus.cfg_half_period == '0) ? CNT_W'(1) : bus.cfg_half_period;
  // A config presented alongside start must take effect for that very burst.
  assign start_half   = cfg_xfer ? cfg_half_eff : half_reg;
  assign pc_inc       = (pc_r == '1) ? pc_r : pc_r + NP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      half_reg  <= CNT_W'(DEF_HALF);
      np_reg    <= '0;
      cnt       <= '0;
      signal_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      pc_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_xfer) begin
            half_reg <= cfg_half_eff;
            np_reg   <= bus.cfg_num_pulses;
          end
          if (bus.start && !bus.stop) begin
            state     <= HIGH;
            signal_r  <= 1'b1;
            busy_r    <= 1'b1;
            pc_r      <= '0;
            aborted_r <= 1'b0;
            cnt       <= start_half - CNT_W'(1);
          end
        end
        HIGH: begin
          if (bus.stop) begin
            state     <= DONE;
            signal_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else if (cnt == '0) begin
            state    <= LOW;
            signal_r <= 1'b0;
            cnt      <= half_reg - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt == '0) begin
            pc_r <= pc_inc;
            // Normal completion outranks a coincident stop.
            if (np_reg != '0 && pc_inc == np_reg) begin
              state     <= DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              aborted_r <= 1'b0;
            end else if (bus.stop) begin
              state     <= DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              aborted_r <= 1'b1;
            end else begin
              state    <= HIGH;
              signal_r <= 1'b1;
              cnt      <= half_reg - CNT_W'(1);
            end
          end else if (bus.stop) begin
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Directed bench for pulse_train_ctrl: expected waveforms and burst results are queued at start and popped as the DUT runs.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_pulse_train_ctrl;
  localparam int CNT_W    = 32;
  localparam int NP_W     = 4;
  localparam int DEF_HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_train_ctrl_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();

  pulse_train_ctrl #(.CNT_W(CNT_W), .NP_W(NP_W), .DEF_HALF(DEF_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int pc;
    bit ab;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  int   mh    = DEF_HALF;
  int   mn    = 0;
  bit   sig_q[$];
  res_t res_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst from IDLE; stop_at is the 0-based burst cycle in which stop is held (-1 for none).
  task automatic burst(input bit do_cfg, input int ch, input int cn, input int stop_at,
                       input bit mid_cfg, input string tag);
    int   len;
    int   pc;
    bit   ab;
    bit   s;
    res_t r;
    if (do_cfg) begin
      bus.cfg_valid       = 1'b1;
      bus.cfg_half_period = CNT_W'(ch);
      bus.cfg_num_pulses  = NP_W'(cn);
      chk({tag, "_cfg_rdy"}, 64'(bus.cfg_ready), 64'd1);
      mh = (ch == 0) ? 1 : ch;
      mn = cn;
    end
    bus.start = 1'b1;
    len = (stop_at >= 0) ? stop_at + 1 : 2 * mn * mh;
    for (int i = 0; i < len; i++) sig_q.push_back(((i / mh) % 2) == 0);
    pc = len / (2 * mh);
    if (pc > (1 << NP_W) - 1) pc = (1 << NP_W) - 1;
    ab = (stop_at >= 0) && !(mn != 0 && len == 2 * mn * mh);
    res_q.push_back('{pc, ab});
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      s = sig_q.pop_front();
      chk({tag, "_signal"}, 64'(bus.signal), 64'(s));
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      if (i == 0) chk({tag, "_aborted_clr"}, 64'(bus.aborted), 64'd0);
      if (mid_cfg && i == 1) begin
        bus.cfg_valid       = 1'b1;
        bus.cfg_half_period = CNT_W'(10);
        bus.cfg_num_pulses  = NP_W'(1);
      end
      if (mid_cfg && i == 2) chk({tag, "_cfg_rdy_busy"}, 64'(bus.cfg_ready), 64'd0);
      if (i == stop_at) bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
    end
    bus.cfg_valid = 1'b0;
    r = res_q.pop_front();
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done_signal"}, 64'(bus.signal), 64'd0);
    chk({tag, "_count"}, 64'(bus.pulse_count), 64'(r.pc));
    chk({tag, "_aborted"}, 64'(bus.aborted), 64'(r.ab));
    chk({tag, "_done_rdy"}, 64'(bus.cfg_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(bus.cfg_ready), 64'd1);
    chk({tag, "_count_hold"}, 64'(bus.pulse_count), 64'(r.pc));
  endtask

  initial begin
    rst                 = 1'b1;
    bus.cfg_valid       = 1'b0;
    bus.cfg_half_period = '0;
    bus.cfg_num_pulses  = '0;
    bus.start           = 1'b0;
    bus.stop            = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_signal", 64'(bus.signal), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_aborted", 64'(bus.aborted), 64'd0);
    chk("rst_count", 64'(bus.pulse_count), 64'd0);
    chk("rst_cfg_rdy", 64'(bus.cfg_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_rdy", 64'(bus.cfg_ready), 64'd1);

    // Default continuous 8/8 train, stopped 3.5 periods in.
    burst(1'b0, 0, 0, 55, 1'b0, "cont_stop");
    burst(1'b1, 3, 4, -1, 1'b0, "h3n4");
    burst(1'b1, 0, 2, -1, 1'b0, "h0n2");
    // Config offered mid-burst must be dropped; the follow-up burst still uses H=5 N=4.
    burst(1'b1, 5, 4, -1, 1'b1, "h5n4_midcfg");
    burst(1'b0, 0, 0, -1, 1'b0, "h5n4_again");
    // Stop coincides with the final LOW terminal count.
    burst(1'b1, 2, 1, 3, 1'b0, "h2n1_stopend");
    // Continuous H=1 for 20 pulses: the 4-bit count saturates.
    burst(1'b1, 1, 0, 39, 1'b0, "sat");

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop_busy", 64'(bus.busy), 64'd0);
    chk("startstop_signal", 64'(bus.signal), 64'd0);
    @(negedge clk);
    chk("startstop_done", 64'(bus.done), 64'd0);

    bus.cfg_valid       = 1'b1;
    bus.cfg_half_period = CNT_W'(3);
    bus.cfg_num_pulses  = NP_W'(0);
    bus.start           = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    chk("pre_rst_signal", 64'(bus.signal), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_signal", 64'(bus.signal), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_cfg_rdy", 64'(bus.cfg_ready), 64'd0);
    rst = 1'b0;
    mh  = DEF_HALF;
    mn  = 0;
    @(negedge clk);
    burst(1'b0, 0, 0, 20, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pulse_train_ctrl.md
Name: pulse_train_ctrl

Overview:
- Programmable pulse-train sequencer that replaces the free-running divide-by-16 strobe with a configured, start/stop-controlled burst.
- Software/host logic loads a half-period and pulse count through a valid/ready config port, then issues start.
- The block drives `signal` with exactly N square pulses, or runs continuously, and reports busy/done/progress.
- Sits between the control register bank and the analog front-end strobe output.

Parameters:
- CNT_W, 32, width of the half-period counter and cfg_half_period.
- NP_W, 16, width of the pulse-count config and the pulse_count output.
- DEF_HALF, 8, half-period loaded at reset; reproduces the legacy divide-by-16 rate.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  config word present.
- cfg_ready  out  1  block accepts config; high only in IDLE.
- cfg_half_period  in  CNT_W  cycles per high phase and per low phase; 0 is treated as 1.
- cfg_num_pulses  in  NP_W  pulses per burst; 0 means continuous until stop.
- start  in  1  begin burst; sampled only in IDLE.
- stop  in  1  abort burst; sampled in HIGH/LOW.
- signal  out  1  registered pulse output.
- busy  out  1  high in HIGH and LOW states.
- done  out  1  one-cycle pulse at end of burst (normal or aborted).
- aborted  out  1  valid with done; 1 if the burst ended by stop.
- pulse_count  out  NP_W  completed pulses in current/last burst; saturates at all-ones.

Behaviour:
- Reset values:
  - signal=0, busy=0, done=0, aborted=0, pulse_count=0.
  - state=IDLE; half_reg=DEF_HALF; np_reg=0.
  - cfg_ready=0 while rst=1, then 1 in IDLE.
- States: IDLE, HIGH, LOW, DONE. All outputs except cfg_ready are registered.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - On transfer, latch half_reg = max(cfg_half_period, 1) and np_reg = cfg_num_pulses.
  - cfg_valid outside IDLE is ignored; no stall, no latch.
- Start:
  - IDLE & start moves to HIGH on the next edge: signal=1, busy=1, pulse_count=0, phase counter loaded with half_reg-1.
  - If a config transfer and start occur in the same cycle, the burst uses the newly presented config values.
- Phase counter:
  - Decrements each cycle.
  - HIGH & counter==0: go to LOW, signal=0, reload half_reg-1.
  - LOW & counter==0: pulse_count += 1 (saturating). Then:
    - if np_reg!=0 and the incremented count == np_reg, go to DONE;
    - otherwise go to HIGH, signal=1, reload.
- Timing:
  - signal high exactly H=half_reg cycles and low exactly H cycles; period 2H.
  - With start sampled at edge t0, signal rises at t0+1.
  - done=1 during cycle t0+1+2NH, with busy=0 in that cycle.
- DONE: done=1, busy=0, signal=0 for one cycle, then IDLE. pulse_count holds until the next start.
- Stop:
  - In HIGH or LOW, stop moves to DONE on the next edge: signal=0 immediately, aborted=1 with done.
  - pulse_count keeps only completed pulses; a partial pulse is not counted.
  - stop and the final LOW terminal count in the same cycle: normal completion wins, aborted=0.
- start & stop together in IDLE: stop wins; no burst, no done.
- start or stop while in DONE: ignored.
- Continuous mode (np_reg=0): runs until stop. pulse_count saturates at 2^NP_W-1 and the pulse train continues.
- rst mid-burst: next edge forces reset values, including half_reg=DEF_HALF; no done pulse.
- aborted clears on the next start.

Test Plan:
- Reset, then start with no config → continuous 8-high/8-low train (period 16); stop after 3.5 periods → signal=0 next cycle, done=1 and aborted=1 for one cycle, pulse_count=3.
- Config H=3, N=4, then start at edge t0 → signal high at t0+1..t0+3, low at t0+4..t0+6, repeated 4×; done at t0+25, pulse_count=4, busy low.
- Config H=0, N=2 → treated as H=1; signal toggles every cycle, done exactly 4 cycles after the first high.
- cfg_valid asserted during a burst (H=5, N=4) with new H=10 → cfg_ready=0, burst keeps H=5; the new value is not latched.
- Same-cycle cfg (H=2, N=1) and start in IDLE → 2 high, 2 low, done; stop asserted together with the final LOW terminal count → aborted=0.
- Assert rst during a HIGH phase → next cycle signal=0, busy=0, done=0, cfg_ready=0; after release, start yields an H=8 train.
